lab62_soc_accent_bank: RTL and testbench
========================================

// Module: lab62_soc_accent_bank
// PURPOSE
//   Avalon-MM slave holding NUM_CH colour/accent registers of WIDTH bits each, driven to the video path as one flat bus.
//   Software writes shadow registers. All channels move to the active set together, either at the next frame_sync
//   (tear-free) or immediately. Per-channel blink gates an output to zero every BLINK_PERIOD frames.
//   Sits between the Nios II data master and the sprite/HUD colour logic.
// PARAMETERS
//   NUM_CH        4    channels, 1..8
//   WIDTH         24   bits per channel, 1..32
//   RESET_VALUE   0    reset value of every shadow and active register (WIDTH bits)
//   BLINK_DEFAULT 30   reset value of BLINK_PERIOD, in frames (16 bits)
// PORTS
//   clk        in   1             system clock
//   reset      in   1             synchronous, active-high reset
//   address    in   5             word address
//   chipselect in   1             Avalon chipselect
//   write_n    in   1             Avalon write strobe, active low
//   writedata  in   32            write data
//   readdata   out  32            read data, read latency 0 (combinational from registers)
//   frame_sync in   1             one-cycle pulse per frame (vsync start), clk domain
//   out_port   out  NUM_CH*WIDTH  channel ch at [ch*WIDTH +: WIDTH], registered
// BEHAVIOUR
//   Write enable: wr = chipselect & ~write_n. Only writedata[WIDTH-1:0] is used for channel registers.
//   Address map (a channel address with ch >= NUM_CH: write ignored, read returns 0):
//     0x00+ch  SHADOW[ch]  RW   shadow <= wd
//     0x08+ch  SET[ch]     WO   shadow <= shadow | wd; reads return SHADOW[ch]
//     0x10+ch  CLR[ch]     WO   shadow <= shadow & ~wd; reads return SHADOW[ch]
//     0x18     CTRL        RW
//                bit0 COMMIT: write 1 arms pending; reads 0
//                bit1 IMMEDIATE: write 1 requests a copy; reads 0
//                [15:8] BLINK_EN mask; bits >= NUM_CH read 0
//     0x19     STATUS      RO   bit0 pending, bit1 blink_phase, [31:16] frame_cnt
//     0x1A     BLINK_PERIOD RW  [15:0]
//     0x1B     ACTIVE_SEL  RW   [2:0] ch; a read of 0x1C returns ACTIVE[ch]
//     0x1C     ACTIVE      RO   other addresses read 0; writes to them are ignored
//   Readdata: registered value zero-extended to 32 bits; upper bits read 0.
//   Commit FSM, states IDLE, ARMED, COPY:
//     IDLE  -> ARMED on a COMMIT write.
//     IDLE/ARMED -> COPY on an IMMEDIATE write. IMMEDIATE wins if COMMIT is written in the same word.
//     ARMED -> COPY on a cycle with frame_sync=1, but not in the cycle the COMMIT write lands.
//       A COMMIT write coincident with frame_sync waits for the next frame_sync.
//     COPY: ACTIVE[all] <= SHADOW[all] in one cycle, taking shadow values as of the end of the previous cycle.
//       A shadow write during COPY lands in shadow only. Then -> IDLE.
//     A further COMMIT while ARMED is a no-op. pending = (state != IDLE).
//   Blink:
//     frame_cnt increments on every frame_sync and wraps at 0xFFFF->0.
//     blink_cnt counts frame_sync pulses. When blink_cnt == BLINK_PERIOD-1: blink_cnt <= 0 and blink_phase toggles.
//     BLINK_PERIOD == 0: blink_cnt and blink_phase held at 0.
//     A BLINK_PERIOD write clears blink_cnt and blink_phase.
//   Output: out_port[ch] <= (BLINK_EN[ch] & blink_phase) ? 0 : ACTIVE[ch].
//     One cycle after any ACTIVE, phase or BLINK_EN change.
//   Reset (any cycle, including mid-ARMED or COPY):
//     SHADOW = ACTIVE = RESET_VALUE; out_port = {NUM_CH{RESET_VALUE}} on the cycle after reset.
//     state IDLE; BLINK_EN = 0; BLINK_PERIOD = BLINK_DEFAULT; frame_cnt, blink_cnt, blink_phase = 0; ACTIVE_SEL = 0.
// TESTING
//   Tear-free commit:
//     Write SHADOW[1]=0xFF0000, then CTRL=1 -> out_port ch1 unchanged, STATUS.pending=1.
//     Pulse frame_sync -> ch1=0xFF0000 two cycles later; pending=0.
//   Immediate path: write SHADOW[0]=0x00FF00, then CTRL=2 -> out_port ch0=0x00FF00 within 3 cycles, no frame_sync needed.
//   Set/clear: SHADOW[2]=0x0F0F0F, SET[2]=0xF00000, CLR[2]=0x00000F -> read 0x02 returns 0xFF0F00.
//   Collision: COMMIT write in the same cycle as frame_sync -> no copy; the copy happens at the next frame_sync only.
//   Blink: BLINK_PERIOD=2, BLINK_EN=0x01, ACTIVE[0]=0x123456 -> ch0 reads 0 after frames 2-3, 0x123456 after 4-5.
//     PERIOD=0 -> output steady.
//   Reset mid-ARMED:
//     Arm a commit, assert reset 1 cycle -> pending=0, out_port=RESET_VALUE.
//     A following frame_sync causes no copy.

Source files
------------

// File: rtl/lab62_soc_accent_bank.sv
// rtl/lab62_soc_accent_bank.sv - Avalon-MM accent/colour register bank with tear-free commit and blink
// Shadow registers are copied to the active set together, then gated by blink onto a flat output bus.
module lab62_soc_accent_bank #(
  parameter int              NUM_CH        = 4,
  parameter int              WIDTH         = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [15:0]     BLINK_DEFAULT = 16'd30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    frame_sync,
  output logic [NUM_CH*WIDTH-1:0] out_port
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_COPY  = 2'd2;

  logic [WIDTH-1:0]  shadow [NUM_CH];
  logic [WIDTH-1:0]  active [NUM_CH];
  logic [NUM_CH-1:0] blink_en;
  logic [15:0]       blink_period;
  logic [15:0]       blink_cnt;
  logic [15:0]       frame_cnt;
  logic              blink_phase;
  logic [2:0]        active_sel;
  logic [1:0]        state, state_nxt;

  logic             wr, ctrl_wr, commit_wr, imm_wr, period_wr, pending;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == 5'h18);
  assign commit_wr = ctrl_wr & writedata[0];
  assign imm_wr    = ctrl_wr & writedata[1];
  assign period_wr = wr && (address == 5'h1A);
  assign wd        = writedata[WIDTH-1:0];
  assign pending   = (state != ST_IDLE);
  assign unused_wd = &{1'b0, writedata};

  // IMMEDIATE outranks COMMIT; a COMMIT landing in IDLE never sees the same-cycle frame_sync.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (imm_wr)         state_nxt = ST_COPY;
        else if (commit_wr) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (imm_wr || frame_sync) state_nxt = ST_COPY;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      blink_en     <= '0;
      blink_period <= BLINK_DEFAULT;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      frame_cnt    <= '0;
      active_sel   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= RESET_VALUE;
        active[i] <= RESET_VALUE;
      end
      out_port <= {NUM_CH{RESET_VALUE}};
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && address[2:0] == i[2:0]) begin
          case (address[4:3])
            2'b00:   shadow[i] <= wd;
            2'b01:   shadow[i] <= shadow[i] | wd;
            2'b10:   shadow[i] <= shadow[i] & ~wd;
            default: ;
          endcase
        end
        if (state == ST_COPY) active[i] <= shadow[i];
        out_port[i*WIDTH +: WIDTH] <= (blink_en[i] & blink_phase) ? '0 : active[i];
      end
      if (ctrl_wr) blink_en <= writedata[8 +: NUM_CH];
      if (wr && address == 5'h1B) active_sel <= writedata[2:0];
      if (frame_sync) frame_cnt <= frame_cnt + 16'd1;
      if (period_wr) begin
        blink_period <= writedata[15:0];
        blink_cnt    <= '0;
        blink_phase  <= 1'b0;
      end else if (frame_sync) begin
        if (blink_period == 16'd0) begin
          blink_cnt   <= '0;
          blink_phase <= 1'b0;
        end else if (blink_cnt == blink_period - 16'd1) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (address[4:3] != 2'b11) begin
      for (int i = 0; i < NUM_CH; i++)
        if (address[2:0] == i[2:0]) readdata[WIDTH-1:0] = shadow[i];
    end else begin
      case (address[2:0])
        3'd0: readdata[8 +: NUM_CH] = blink_en;
        3'd1: readdata = {frame_cnt, 14'd0, blink_phase, pending};
        3'd2: readdata[15:0] = blink_period;
        3'd3: readdata[2:0] = active_sel;
        3'd4: begin
          for (int i = 0; i < NUM_CH; i++)
            if (active_sel == i[2:0]) readdata[WIDTH-1:0] = active[i];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab62_soc_accent_bank.sv
// tb/tb_lab62_soc_accent_bank.sv - directed self-checking bench for lab62_soc_accent_bank
module tb_lab62_soc_accent_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        frame_sync = 1'b0;
  logic [95:0] out_port;

  int vectors = 0;
  int miscompares = 0;
  int frames = 0;

  lab62_soc_accent_bank dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .frame_sync(frame_sync), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse_fs;
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    frames++;
  endtask

  function automatic logic [23:0] ch(input int c);
    return out_port[c*24 +: 24];
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; tick(2); reset = 1'b0;
    frames = 0;
    vectors++; if (out_port !== 96'h0) begin $display("FAIL reset_out got %h exp 0", out_port); miscompares++; end
    bus_read(5'h19, d);
    vectors++; if (d !== 32'h0) begin $display("FAIL reset_status got %h exp 0", d); miscompares++; end
    bus_read(5'h1A, d);
    vectors++; if (d !== 32'd30) begin $display("FAIL reset_period got %h exp 1e", d); miscompares++; end
    bus_read(5'h18, d);
    vectors++; if (d !== 32'h0) begin $display("FAIL reset_ctrl got %h exp 0", d); miscompares++; end
  endtask

  task automatic test_tear_free;
    logic [31:0] d;
    bus_write(5'h01, 32'h00FF0000);
    bus_write(5'h18, 32'h1);
    tick(3);
    vectors++; if (ch(1) !== 24'h0) begin $display("FAIL tf_hold got %h exp 0", ch(1)); miscompares++; end
    bus_read(5'h19, d);
    vectors++; if (d[0] !== 1'b1) begin $display("FAIL tf_pending got %b exp 1", d[0]); miscompares++; end
    pulse_fs;
    tick(1);
    vectors++; if (ch(1) !== 24'h0) begin $display("FAIL tf_early got %h exp 0", ch(1)); miscompares++; end
    tick(1);
    vectors++; if (ch(1) !== 24'hFF0000) begin $display("FAIL tf_copy got %h exp ff0000", ch(1)); miscompares++; end
    bus_read(5'h19, d);
    vectors++; if (d[0] !== 1'b0) begin $display("FAIL tf_pending_clr got %b exp 0", d[0]); miscompares++; end
  endtask

  task automatic test_immediate;
    logic [31:0] d;
    bus_write(5'h00, 32'h0000FF00);
    bus_write(5'h18, 32'h3);
    tick(2);
    vectors++; if (ch(0) !== 24'h00FF00) begin $display("FAIL imm_out got %h exp 00ff00", ch(0)); miscompares++; end
    bus_read(5'h19, d);
    vectors++; if (d[0] !== 1'b0) begin $display("FAIL imm_pending got %b exp 0", d[0]); miscompares++; end
  endtask

  task automatic test_set_clear;
    logic [31:0] d;
    bus_write(5'h02, 32'h000F0F0F);
    bus_write(5'h0A, 32'h00F00000);
    bus_write(5'h12, 32'h0000000F);
    bus_read(5'h02, d);
    vectors++; if (d !== 32'h00FF0F00) begin $display("FAIL setclr_shadow got %h exp 00ff0f00", d); miscompares++; end
    bus_read(5'h0A, d);
    vectors++; if (d !== 32'h00FF0F00) begin $display("FAIL setclr_setread got %h exp 00ff0f00", d); miscompares++; end
    bus_read(5'h12, d);
    vectors++; if (d !== 32'h00FF0F00) begin $display("FAIL setclr_clrread got %h exp 00ff0f00", d); miscompares++; end
    vectors++; if (ch(2) !== 24'h0) begin $display("FAIL setclr_noact got %h exp 0", ch(2)); miscompares++; end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    bus_write(5'h03, 32'h00ABCDEF);
    frame_sync = 1'b1;
    bus_write(5'h18, 32'h1);
    frame_sync = 1'b0;
    frames++;
    tick(4);
    vectors++; if (ch(3) !== 24'h0) begin $display("FAIL coll_nocopy got %h exp 0", ch(3)); miscompares++; end
    bus_read(5'h19, d);
    vectors++; if (d[0] !== 1'b1) begin $display("FAIL coll_pending got %b exp 1", d[0]); miscompares++; end
    pulse_fs;
    tick(2);
    vectors++; if (ch(3) !== 24'hABCDEF) begin $display("FAIL coll_copy got %h exp abcdef", ch(3)); miscompares++; end
    vectors++; if (ch(2) !== 24'hFF0F00) begin $display("FAIL coll_ch2 got %h exp ff0f00", ch(2)); miscompares++; end
  endtask

  task automatic test_blink;
    logic [23:0] exp_tbl [1:5];
    logic [31:0] d;
    exp_tbl[1] = 24'h123456; exp_tbl[2] = 24'h0; exp_tbl[3] = 24'h0;
    exp_tbl[4] = 24'h123456; exp_tbl[5] = 24'h123456;
    bus_write(5'h00, 32'h00123456);
    bus_write(5'h18, 32'h2);
    tick(2);
    bus_write(5'h1A, 32'h2);
    bus_write(5'h18, 32'h0100);
    tick(1);
    vectors++; if (ch(0) !== 24'h123456) begin $display("FAIL blink_f0 got %h exp 123456", ch(0)); miscompares++; end
    for (int f = 1; f <= 5; f++) begin
      pulse_fs;
      tick(1);
      vectors++;
      if (ch(0) !== exp_tbl[f]) begin
        $display("FAIL blink_frame%0d got %h exp %h", f, ch(0), exp_tbl[f]); miscompares++;
      end
    end
    bus_read(5'h18, d);
    vectors++; if (d !== 32'h00000100) begin $display("FAIL blink_ctrl_rd got %h exp 100", d); miscompares++; end
    bus_write(5'h1A, 32'h0);
    for (int f = 0; f < 3; f++) begin
      pulse_fs;
      tick(1);
      vectors++; if (ch(0) !== 24'h123456) begin $display("FAIL blink_p0_f%0d got %h exp 123456", f, ch(0)); miscompares++; end
    end
    bus_read(5'h19, d);
    vectors++; if (d !== {frames[15:0], 16'h0}) begin $display("FAIL frame_cnt got %h exp %h", d, {frames[15:0], 16'h0}); miscompares++; end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    bus_write(5'h18, 32'h0000FF00);
    bus_read(5'h18, d);
    vectors++; if (d !== 32'h00000F00) begin $display("FAIL blink_en_mask got %h exp f00", d); miscompares++; end
    bus_write(5'h1B, 32'h3);
    bus_read(5'h1C, d);
    vectors++; if (d !== 32'h00ABCDEF) begin $display("FAIL active_rd got %h exp abcdef", d); miscompares++; end
    bus_write(5'h1B, 32'h5);
    bus_read(5'h1C, d);
    vectors++; if (d !== 32'h0) begin $display("FAIL active_oob got %h exp 0", d); miscompares++; end
    bus_write(5'h04, 32'h00111111);
    bus_read(5'h04, d);
    vectors++; if (d !== 32'h0) begin $display("FAIL ch_oob got %h exp 0", d); miscompares++; end
    bus_read(5'h00, d);
    vectors++; if (d !== 32'h00123456) begin $display("FAIL ch0_intact got %h exp 123456", d); miscompares++; end
  endtask

  task automatic test_reset_armed;
    logic [31:0] d;
    bus_write(5'h02, 32'h00777777);
    bus_write(5'h18, 32'h1);
    reset = 1'b1; tick(1); reset = 1'b0;
    frames = 0;
    bus_read(5'h19, d);
    vectors++; if (d !== 32'h0) begin $display("FAIL rst_status got %h exp 0", d); miscompares++; end
    vectors++; if (out_port !== 96'h0) begin $display("FAIL rst_out got %h exp 0", out_port); miscompares++; end
    pulse_fs;
    tick(3);
    vectors++; if (out_port !== 96'h0) begin $display("FAIL rst_nocopy got %h exp 0", out_port); miscompares++; end
    bus_read(5'h02, d);
    vectors++; if (d !== 32'h0) begin $display("FAIL rst_shadow got %h exp 0", d); miscompares++; end
    bus_read(5'h1A, d);
    vectors++; if (d !== 32'd30) begin $display("FAIL rst_period got %h exp 1e", d); miscompares++; end
  endtask

  initial begin
    tick(1);
    test_reset;
    test_tear_free;
    test_immediate;
    test_set_clear;
    test_collision;
    test_blink;
    test_regs;
    test_reset_armed;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
